// File: rtl/bcd_down_timer_pkg.sv
// Shared types for the BCD countdown timer: digit type, FSM states and status bundle.
package bcd_timer_pkg;

  localparam int         MAX_NDIG = 8;
  localparam logic [3:0] MAXDIG   = 4'd9;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } tmr_state_e;

  // Count is sized for the widest build; narrower builds zero-extend.
  typedef struct packed {
    logic [4*MAX_NDIG-1:0] count;
    tmr_state_e            state;
    logic                  done;
  } tmr_t;

endpackage

// File: rtl/bcd_down_timer_if.sv
// Command/status bundle between a controller and the BCD countdown timer.
interface bcd_down_timer_if #(
  parameter int NDIG = 4
);

  logic              i_clr;
  logic              i_load;
  logic [4*NDIG-1:0] i_load_val;
  logic              i_start;
  logic              i_pause;
  logic              i_tick;
  logic [4*NDIG-1:0] o_count;
  logic              o_busy;
  logic              o_done;
  logic              o_zero;

  modport master (
    output i_clr, i_load, i_load_val, i_start, i_pause, i_tick,
    input  o_count, o_busy, o_done, o_zero
  );

  modport slave (
    input  i_clr, i_load, i_load_val, i_start, i_pause, i_tick,
    output o_count, o_busy, o_done, o_zero
  );

endinterface

// File: rtl/bcd_down_timer_digit_dn.sv
// One BCD down-counting digit with borrow-in/borrow-out; wraps 0 -> MAX on borrow.
module bcd_digit_dn
  import bcd_timer_pkg::*;
#(
  parameter bcd_digit_t MAX = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_load,
  input  bcd_digit_t i_load_val,
  input  logic       i_bin,
  output logic       o_bout,
  output bcd_digit_t o_digit
);

  bcd_digit_t dig_p0;

  // Stage p0: digit register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dig_p0 <= '0;
    end else if (i_clr) begin
      dig_p0 <= '0;
    end else if (i_load) begin
      dig_p0 <= i_load_val;
    end else if (i_bin) begin
      dig_p0 <= (dig_p0 == '0) ? MAX : dig_p0 - 4'd1;
    end
  end

  assign o_bout  = i_bin & (dig_p0 == '0);
  assign o_digit = dig_p0;

endmodule

// File: rtl/bcd_down_timer.sv
// Loadable multi-digit BCD countdown timer with one-cycle terminal-count pulse.
// Optional build macro BCD_DOWN_TIMER_AUTO_RELOAD_EN: reload from the last loaded value at terminal count.
module bcd_down_timer #(
  parameter int         NDIG   = 4,
  parameter logic [3:0] MAXDIG = 4'd9
) (
  input logic             clk,
  input logic             rst,
  bcd_down_timer_if.slave bus
);

  import bcd_timer_pkg::*;

  localparam int CW = 4*NDIG;

  tmr_state_e    state_p0, state_nx;
  logic          done_p0, done_nx;
  logic [CW-1:0] count;
  logic [NDIG:0] borrow;
  logic          dig_clr, dig_load, dec_en;
  logic [CW-1:0] dig_load_val;
  logic          count_zero, count_one;
  tmr_t          cur;

`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
  logic [CW-1:0] reload_p0;
  logic          reload_we;
`endif

  function automatic bcd_digit_t sat_digit(input bcd_digit_t d);
    return (d > MAXDIG) ? MAXDIG : d;
  endfunction

  function automatic logic [CW-1:0] sat_value(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    r = '0;
    for (int k = 0; k < NDIG; k++) begin
      r[4*k +: 4] = sat_digit(v[4*k +: 4]);
    end
    return r;
  endfunction

  always_comb begin
    cur           = '0;
    cur.count[CW-1:0] = count;
    cur.state     = state_p0;
    cur.done      = done_p0;
  end

  assign count_zero = (cur.count == '0);
  assign count_one  = (cur.count == (4*MAX_NDIG)'(1));

  always_comb begin
    state_nx     = state_p0;
    done_nx      = 1'b0;
    dig_clr      = 1'b0;
    dig_load     = 1'b0;
    dig_load_val = sat_value(bus.i_load_val);
    dec_en       = 1'b0;
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
    reload_we    = 1'b0;
`endif
    if (bus.i_clr) begin
      dig_clr  = 1'b1;
      state_nx = IDLE;
    end else if (bus.i_load && (state_p0 != RUN)) begin
      dig_load = 1'b1;
      state_nx = IDLE;
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
      reload_we = 1'b1;
`endif
    end else if (bus.i_start && ((state_p0 == IDLE) || (state_p0 == PAUSE))) begin
      if (count_zero) begin
        state_nx = DONE;
        done_nx  = 1'b1;
      end else begin
        state_nx = RUN;
      end
    end else if (bus.i_pause && (state_p0 == RUN)) begin
      state_nx = PAUSE;
    end else if (bus.i_tick && (state_p0 == RUN)) begin
      dec_en = 1'b1;
      if (count_one) begin
        done_nx = 1'b1;
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
        if (reload_p0 != '0) begin
          dig_load     = 1'b1;
          dig_load_val = reload_p0;
          dec_en       = 1'b0;
        end else begin
          state_nx = DONE;
        end
`else
        state_nx = DONE;
`endif
      end
    end
  end

  // Stage p0: control registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_p0 <= IDLE;
      done_p0  <= 1'b0;
    end else begin
      state_p0 <= state_nx;
      done_p0  <= done_nx;
    end
  end

`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reload_p0 <= '0;
    end else if (reload_we) begin
      reload_p0 <= dig_load_val;
    end
  end
`endif

  // A borrow out of the top digit would wrap the count to all-MAX; hold at zero instead.
  assign borrow[0] = dec_en;

  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    bcd_digit_dn #(
      .MAX (MAXDIG)
    ) u_dig (
      .clk        (clk),
      .rst        (rst),
      .i_clr      (dig_clr | borrow[NDIG]),
      .i_load     (dig_load),
      .i_load_val (dig_load_val[4*g +: 4]),
      .i_bin      (borrow[g]),
      .o_bout     (borrow[g+1]),
      .o_digit    (count[4*g +: 4])
    );
  end

  assign bus.o_count = cur.count[CW-1:0];
  assign bus.o_busy  = (cur.state == RUN) || (cur.state == PAUSE);
  assign bus.o_done  = cur.done;
  assign bus.o_zero  = count_zero;

endmodule
